axil_regbank_n: RTL and testbench

Parametrised AXI4-Lite slave register bank. It generalises the fixed four-register control slave to NUM_REGS registers of configurable width, per-register read-only masking, byte strobes and SLVERR decode. It sits between the SOM-side AXI interconnect (master VIP in simulation) and modem fabric logic. It exposes the register contents, write pulses and read-only status inputs to the fabric.

---
 rtl/axil_regbank_n.sv | 216 +++++++++++++++++++++
 tb/tb_axil_regbank_n.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regbank_n.sv
// rtl/axil_regbank_n.sv - parametrised AXI4-Lite slave register bank
// Define AXIL_REGBANK_W1C_EN to turn read-only registers into sticky write-1-to-clear status.
module axil_regbank_n #(
  parameter int                             DATA_WIDTH = 32,
  parameter int                             NUM_REGS   = 16,
  parameter int                             ADDR_WIDTH = 12,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            awaddr,
  input  logic [2:0]                       awprot,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [ADDR_WIDTH-1:0]            araddr,
  input  logic [2:0]                       arprot,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   status_in
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int CMP_W  = IDX_W + 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "axil_regbank_n: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
    $fatal(1, "axil_regbank_n: NUM_REGS must be in 1..256");
  end
  if (IDX_W < $clog2(NUM_REGS)) begin : g_bad_addr_width
    $fatal(1, "axil_regbank_n: ADDR_WIDTH too small for NUM_REGS");
  end

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t                       w_state;
  r_state_t                       r_state;
  logic                           aw_full;
  logic                           w_full;
  logic [IDX_W-1:0]               aw_idx;
  logic [DATA_WIDTH-1:0]          w_data;
  logic [STRB_W-1:0]              w_strb;
  logic [DATA_WIDTH-1:0]          w_mask;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs;
  logic [NUM_REGS*DATA_WIDTH-1:0] ro_val;
  logic [IDX_W-1:0]               ar_idx;
  logic                           aw_in_range;
  logic                           ar_in_range;
  logic                           commit;
  logic [DATA_WIDTH-1:0]          rd_val;

  // Ready depends on reset combinationally so it is low throughout the reset cycle.
  assign awready = !reset && (w_state == W_IDLE) && !aw_full;
  assign wready  = !reset && (w_state == W_IDLE) && !w_full;
  assign arready = !reset && (r_state == R_IDLE);

  assign commit      = (w_state == W_IDLE) && aw_full && w_full;
  assign ar_idx      = araddr[ADDR_WIDTH-1:LSB];
  assign aw_in_range = {1'b0, aw_idx} < CMP_W'(NUM_REGS);
  assign ar_in_range = {1'b0, ar_idx} < CMP_W'(NUM_REGS);

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      w_mask[b*8 +: 8] = {8{w_strb[b]}};
    end
  end

`ifdef AXIL_REGBANK_W1C_EN
  logic [NUM_REGS*DATA_WIDTH-1:0] sticky;

  // Status set is ORed after the clear so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (RO_MASK[k]) begin
          if (commit && aw_idx == IDX_W'(k)) begin
            sticky[k*DATA_WIDTH +: DATA_WIDTH] <=
              (sticky[k*DATA_WIDTH +: DATA_WIDTH] & ~(w_data & w_mask)) |
              status_in[k*DATA_WIDTH +: DATA_WIDTH];
          end else begin
            sticky[k*DATA_WIDTH +: DATA_WIDTH] <=
              sticky[k*DATA_WIDTH +: DATA_WIDTH] | status_in[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  assign ro_val = sticky;
`else
  assign ro_val = status_in;
`endif

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_out[k*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[k] ? ro_val[k*DATA_WIDTH +: DATA_WIDTH]
                                                       : regs[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_val = reg_out[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state  <= W_IDLE;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= '0;
      regs     <= RST_VAL;
    end else begin
      wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            aw_full <= 1'b1;
            aw_idx  <= awaddr[ADDR_WIDTH-1:LSB];
          end
          if (wvalid && wready) begin
            w_full <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
          end
          if (commit) begin
            bvalid  <= 1'b1;
            bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
            for (int k = 0; k < NUM_REGS; k++) begin
              if (aw_idx == IDX_W'(k) && !RO_MASK[k]) begin
                regs[k*DATA_WIDTH +: DATA_WIDTH] <=
                  (regs[k*DATA_WIDTH +: DATA_WIDTH] & ~w_mask) | (w_data & w_mask);
                wr_pulse[k] <= 1'b1;
              end
            end
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            bvalid  <= 1'b0;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rdata   <= rd_val;
            rresp   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid  <= 1'b1;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Protection bits, byte offsets and the unselected halves of the register muxes carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0], regs, ro_val, status_in};

endmodule

// File: tb/tb_axil_regbank_n.sv
// tb/tb_axil_regbank_n.sv - randomized self-checking bench for axil_regbank_n
`timescale 1ns/1ps
module tb_axil_regbank_n;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 12;
  localparam logic [NR-1:0] RO = 16'h0008;

  function automatic logic [NR*DW-1:0] mk_rst();
    logic [NR*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = 32'hA500_0000 + 32'(k) * 32'h0001_0101;
    return v;
  endfunction
  localparam logic [NR*DW-1:0] RST = mk_rst();

  logic              clock, reset;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*DW-1:0]  reg_out, status_in;
  logic [NR-1:0]     wr_pulse;

  axil_regbank_n #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO), .RST_VAL(RST)) dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];
  logic [31:0] sticky_m;
  int pulse_cnt [NR];

  always @(negedge clock) begin
    for (int k = 0; k < NR; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;
  end

  function automatic int sum_pulses();
    int s = 0;
    for (int k = 0; k < NR; k++) s += pulse_cnt[k];
    return s;
  endfunction

  function automatic logic [31:0] exp_ro();
`ifdef AXIL_REGBANK_W1C_EN
    return sticky_m;
`else
    return status_in[3*DW +: DW];
`endif
  endfunction

  function automatic logic [31:0] exp_read(int idx);
    if (idx >= NR) return 32'h0;
    if (RO[idx]) return exp_ro();
    return model[idx];
  endfunction

  function automatic logic [NR*DW-1:0] exp_image();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = exp_read(k);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model[k] = RST[k*DW +: DW];
    sticky_m = 32'h0;
  endtask

  task automatic model_write(int idx, logic [31:0] d, logic [3:0] s);
    if (idx < NR && !RO[idx]) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    end
`ifdef AXIL_REGBANK_W1C_EN
    if (idx < NR && RO[idx]) begin
      for (int b = 0; b < 4; b++) if (s[b]) sticky_m[b*8 +: 8] = sticky_m[b*8 +: 8] & ~d[b*8 +: 8];
    end
`endif
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge clock);
    awaddr = addr; awprot = 3'($urandom); awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clock); n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL write_bvalid addr=%h got=%b exp=1", addr, bvalid);
    end
    resp = bresp;
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] d, output logic [1:0] resp);
    bit hs;
    int n;
    hs = 0; n = 0;
    @(negedge clock);
    araddr = addr; arprot = 3'($urandom); arvalid = 1'b1;
    while (!hs && n < 50) begin
      hs = arready;
      @(negedge clock); n++;
    end
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL read_latency addr=%h rvalid=%b exp=1", addr, rvalid);
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got=%b exp=000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, wr_pulse} !== '0) begin
      errors++; $display("FAIL reset_valid got=%b/%b/%h exp=0", bvalid, rvalid, wr_pulse);
    end
    checks++;
    if ({rdata, bresp, rresp} !== '0) begin
      errors++; $display("FAIL reset_data got=%h/%b/%b exp=0", rdata, bresp, rresp);
    end
    checks++;
    if (reg_out !== exp_image()) begin
      errors++; $display("FAIL reset_image got=%h exp=%h", reg_out, exp_image());
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready got=%b exp=111", {awready, wready, arready});
    end
  endtask

  task automatic test_seq_write_read();
    int base [NR];
    logic [31:0] got;
    logic [1:0] resp;
    for (int k = 0; k < NR; k++) base[k] = pulse_cnt[k];
    for (int k = 0; k < NR; k++) begin
      do_write(AW'(k*4), 32'(k+1), 4'hF, resp);
      model_write(k, 32'(k+1), 4'hF);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL seq_bresp reg=%0d got=%b exp=00", k, resp); end
    end
    for (int k = 0; k < NR; k++) begin
      do_read(AW'(k*4), got, resp);
      checks++;
      if (got !== exp_read(k) || resp !== 2'b00) begin
        errors++; $display("FAIL seq_read reg=%0d got=%h/%b exp=%h/00", k, got, resp, exp_read(k));
      end
      checks++;
      if (pulse_cnt[k] - base[k] != (RO[k] ? 0 : 1)) begin
        errors++; $display("FAIL seq_pulse reg=%0d got=%0d exp=%0d", k, pulse_cnt[k]-base[k], RO[k] ? 0 : 1);
      end
    end
  endtask

  task automatic test_strobe();
    logic [31:0] got;
    logic [1:0] resp;
    do_write(12'h008, 32'h1122_3344, 4'hF, resp);
    model_write(2, 32'h1122_3344, 4'hF);
    do_write(12'h008, 32'hAABB_CCDD, 4'b0101, resp);
    model_write(2, 32'hAABB_CCDD, 4'b0101);
    do_read(12'h008, got, resp);
    checks++;
    if (got !== 32'h11BB_33DD || got !== model[2]) begin
      errors++; $display("FAIL strobe got=%h exp=%h", got, 32'h11BB_33DD);
    end
  endtask

  task automatic test_w_before_aw();
    int tot0, p7;
    logic [31:0] got;
    logic [1:0] resp;
    tot0 = sum_pulses(); p7 = pulse_cnt[7];
    @(negedge clock);
    wdata = 32'hC0DE_0007; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock);
    wvalid = 1'b0;
    checks++;
    if ({wready, awready} !== 2'b01) begin
      errors++; $display("FAIL w_held_ready got=%b exp=01", {wready, awready});
    end
    repeat (2) @(negedge clock);
    awaddr = 12'h01C; awvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0;
    @(negedge clock);
    awaddr = 12'h020; awvalid = 1'b1; wdata = 32'hBAD0_0008; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
        errors++; $display("FAIL bhold cycle=%0d got=%b exp=10000", i, {bvalid, bresp, awready, wready});
      end
      @(negedge clock);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    model_write(7, 32'hC0DE_0007, 4'hF);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_release got=%b exp=0", bvalid); end
    checks++;
    if (sum_pulses() - tot0 != 1 || pulse_cnt[7] - p7 != 1) begin
      errors++; $display("FAIL w_first_commits got=%0d exp=1", sum_pulses() - tot0);
    end
    do_read(12'h01C, got, resp);
    checks++;
    if (got !== model[7]) begin errors++; $display("FAIL w_first_read got=%h exp=%h", got, model[7]); end
    do_read(12'h020, got, resp);
    checks++;
    if (got !== model[8]) begin errors++; $display("FAIL w_first_noaccept got=%h exp=%h", got, model[8]); end
  endtask

  task automatic test_back_to_back();
    int t [3];
    int cnt, n;
    cnt = 0; n = 0;
    @(negedge clock);
    awaddr = 12'h000; awvalid = 1'b1; wdata = 32'h5A5A_0001; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    while (cnt < 3 && n < 60) begin
      @(negedge clock); n++;
      if (wr_pulse[0] === 1'b1) begin t[cnt] = n; cnt++; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clock);
    bready = 1'b0;
    model_write(0, 32'h5A5A_0001, 4'hF);
    checks++;
    if (cnt != 3 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      errors++; $display("FAIL throughput got=%0d commits gaps %0d/%0d exp=3 commits gaps 3/3",
                         cnt, t[1]-t[0], t[2]-t[1]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] got;
    logic [1:0] resp;
    do_write(12'h014, 32'h0000_AAAA, 4'hF, resp);
    model_write(5, 32'h0000_AAAA, 4'hF);
    @(negedge clock);
    awaddr = 12'h014; awvalid = 1'b1; wdata = 32'h0000_BBBB; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 12'h014; arvalid = 1'b1;
    @(negedge clock);
    arvalid = 1'b0;
    checks++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'h0000_AAAA) begin
      errors++; $display("FAIL same_edge got=%b/%h exp=11/%h", {rvalid, bvalid}, rdata, 32'h0000_AAAA);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clock);
    rready = 1'b0; bready = 1'b0;
    model_write(5, 32'h0000_BBBB, 4'hF);
    do_read(12'h014, got, resp);
    checks++;
    if (got !== model[5]) begin errors++; $display("FAIL same_edge_after got=%h exp=%h", got, model[5]); end
  endtask

  task automatic test_out_of_range();
    int tot0;
    logic [31:0] got;
    logic [1:0] resp;
    tot0 = sum_pulses();
    do_write(12'h040, 32'hFFFF_FFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got=%b exp=10", resp); end
    checks++;
    if (sum_pulses() != tot0 || reg_out !== exp_image()) begin
      errors++; $display("FAIL oor_side_effect pulses=%0d exp=%0d", sum_pulses(), tot0);
    end
    do_read(12'h040, got, resp);
    checks++;
    if (got !== 32'h0 || resp !== 2'b10) begin
      errors++; $display("FAIL oor_read got=%h/%b exp=00000000/10", got, resp);
    end
  endtask

  task automatic test_ro();
    int p3;
    logic [31:0] got;
    logic [1:0] resp;
    p3 = pulse_cnt[3];
`ifdef AXIL_REGBANK_W1C_EN
    @(negedge clock);
    status_in[3*DW] = 1'b1;
    @(negedge clock);
    status_in[3*DW] = 1'b0;
    sticky_m = sticky_m | 32'h1;
    do_read(12'h00C, got, resp);
    checks++;
    if (got !== 32'h1) begin errors++; $display("FAIL w1c_set got=%h exp=00000001", got); end
    do_write(12'h00C, 32'h1, 4'hF, resp);
    model_write(3, 32'h1, 4'hF);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL w1c_bresp got=%b exp=00", resp); end
    do_read(12'h00C, got, resp);
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL w1c_clear got=%h exp=00000000", got); end
`else
    status_in[3*DW +: DW] = 32'hDEAD_BEEF;
    do_write(12'h00C, 32'h0, 4'hF, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL ro_bresp got=%b exp=00", resp); end
    do_read(12'h00C, got, resp);
    checks++;
    if (got !== 32'hDEAD_BEEF || resp !== 2'b00) begin
      errors++; $display("FAIL ro_read got=%h/%b exp=deadbeef/00", got, resp);
    end
`endif
    checks++;
    if (pulse_cnt[3] != p3) begin errors++; $display("FAIL ro_pulse got=%0d exp=%0d", pulse_cnt[3], p3); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [31:0] d, got;
    logic [3:0] s;
    logic [1:0] resp;
    int idx, tot0;
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(0, 19));
      a = AW'(idx * 4) + AW'($urandom_range(0, 3));
`ifndef AXIL_REGBANK_W1C_EN
      status_in[3*DW +: DW] = $urandom;
`endif
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        tot0 = sum_pulses();
        do_write(a, d, s, resp);
        model_write(idx, d, s);
        checks++;
        if (resp !== ((idx < NR) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL rand_bresp addr=%h got=%b", a, resp);
        end
        checks++;
        if (sum_pulses() - tot0 != ((idx < NR && !RO[idx]) ? 1 : 0)) begin
          errors++; $display("FAIL rand_pulse addr=%h got=%0d", a, sum_pulses() - tot0);
        end
      end else begin
        do_read(a, got, resp);
        checks++;
        if (got !== exp_read(idx) || resp !== ((idx < NR) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL rand_read addr=%h got=%h/%b exp=%h", a, got, resp, exp_read(idx));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    logic [1:0] resp;
    do_write(12'h024, 32'h0909_0909, 4'hF, resp);
    model_write(9, 32'h0909_0909, 4'hF);
    @(negedge clock);
    araddr = 12'h024; arvalid = 1'b1;
    @(negedge clock);
    arvalid = 1'b0; wdata = 32'hDEAD_0000; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock);
    wvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_rvalid got=%b exp=1", rvalid); end
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    checks++;
    if ({rvalid, bvalid} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_valid got=%b exp=00", {rvalid, bvalid});
    end
    checks++;
    if (reg_out !== exp_image()) begin
      errors++; $display("FAIL mid_reset_image got=%h exp=%h", reg_out, exp_image());
    end
    reset = 1'b0;
    do_write(12'h024, 32'h1357_2468, 4'hF, resp);
    model_write(9, 32'h1357_2468, 4'hF);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL mid_fresh_bresp got=%b exp=00", resp); end
    do_read(12'h024, got, resp);
    checks++;
    if (got !== model[9]) begin errors++; $display("FAIL mid_fresh_read got=%h exp=%h", got, model[9]); end
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = '0;
`ifndef AXIL_REGBANK_W1C_EN
    status_in[3*DW +: DW] = 32'h1234_5678;
`endif
    model_reset();
    test_reset();
    test_seq_write_read();
    test_strobe();
    test_w_before_aw();
    test_back_to_back();
    test_same_edge();
    test_out_of_range();
    test_ro();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
